// File: rtl/timer_cmd_pkg.sv
// Shared types and constants for the fancy-timer command initiator.
// The optional measurement counter is enabled by TIMER_CMD_TX_MEASURE_EN.
package timer_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_DLY,
        ST_ARM,
        ST_RUN,
        ST_ACK,
        ST_ERR
    } state_e;

    localparam logic [3:0] PREAMBLE_DEF    = 4'b1101;
    localparam int         ARM_TIMEOUT_DEF = 4;
    localparam int         UNIT_CYCLES     = 1000;
    // Longest legal run is 16 units; the extra 16 cycles absorb handshake slack.
    localparam int         WDOG_LIMIT      = 16 * UNIT_CYCLES + 16;

endpackage

// File: rtl/timer_cmd_ser.sv
// 8-bit load/shift serializer, MSB first, with a bit counter.
// msb_next is the bit the line will carry after the coming edge.
module timer_cmd_ser
    import timer_cmd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       shift,
    input  logic [7:0] load_val,
    output logic       msb_next,
    output logic       half_bit,
    output logic       last_bit
);

    logic [7:0] sreg_q, sreg_d;
    logic [2:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        sreg_d = sreg_q;
        cnt_d  = cnt_q;
        if (load) begin
            sreg_d = load_val;
            cnt_d  = 3'd0;
        end else if (shift) begin
            sreg_d = {sreg_q[6:0], 1'b0};
            cnt_d  = cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset) begin
            sreg_q <= '0;
            cnt_q  <= '0;
        end else begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
        end
    end

    assign msb_next = sreg_d[7];
    assign half_bit = (cnt_q == 3'd3);
    assign last_bit = (cnt_q == 3'd7);

endmodule

// File: rtl/timer_cmd_tx.sv
// Command initiator for the serial fancy-timer: sends preamble+delay, tracks
// counting/done, acks completion. Define TIMER_CMD_TX_MEASURE_EN for the cycle counter/watchdog.
module timer_cmd_tx
    import timer_cmd_pkg::*;
#(
    parameter int         DELAY_W     = 4,
    parameter logic [3:0] PREAMBLE    = PREAMBLE_DEF,
    parameter int         ARM_TIMEOUT = ARM_TIMEOUT_DEF,
    parameter int         CYC_W       = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    input  logic [DELAY_W-1:0] req_delay,
    output logic               req_ready,
    output logic               data,
    input  logic               counting,
    input  logic               done,
    output logic               ack,
    output logic               busy,
    output logic               rsp_valid,
    output logic               rsp_err,
    output logic [CYC_W-1:0]   rsp_cycles
);

    localparam int ARM_W = $clog2(ARM_TIMEOUT + 1);

    state_e             state_q, state_d;
    logic [ARM_W-1:0]   arm_cnt_q, arm_cnt_d;
    logic               data_q, data_d;
    logic               ack_q, ack_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_err_q, rsp_err_d;
    logic [CYC_W-1:0]   rsp_cycles_q, rsp_cycles_d;
    logic [CYC_W-1:0]   cyc_d;
    logic               wdog_hit;
    logic               ser_load, ser_shift;
    logic               ser_msb_next, ser_half, ser_last;

    timer_cmd_ser u_ser (
        .clk      (clk),
        .reset    (reset),
        .load     (ser_load),
        .shift    (ser_shift),
        .load_val ({PREAMBLE, req_delay}),
        .msb_next (ser_msb_next),
        .half_bit (ser_half),
        .last_bit (ser_last)
    );

`ifdef TIMER_CMD_TX_MEASURE_EN
    logic [CYC_W-1:0] cyc_q;

    // ARM counts too: the cycle counting rises is the first measured cycle.
    always_comb begin
        cyc_d = cyc_q;
        if (ser_load)
            cyc_d = '0;
        else if ((state_q == ST_ARM || state_q == ST_RUN) && counting && !(&cyc_q))
            cyc_d = cyc_q + CYC_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) cyc_q <= '0;
        else       cyc_q <= cyc_d;
    end

    assign wdog_hit = (cyc_q >= CYC_W'(WDOG_LIMIT));
`else
    assign cyc_d    = '0;
    assign wdog_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        arm_cnt_d = arm_cnt_q;
        ser_load  = 1'b0;
        ser_shift = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    ser_load  = 1'b1;
                    arm_cnt_d = '0;
                    state_d   = ST_PRE;
                end
            end
            ST_PRE: begin
                ser_shift = 1'b1;
                if (ser_half) state_d = ST_DLY;
            end
            ST_DLY: begin
                ser_shift = 1'b1;
                if (ser_last) state_d = ST_ARM;
            end
            ST_ARM: begin
                if (counting)
                    state_d = ST_RUN;
                else if (arm_cnt_q == ARM_W'(ARM_TIMEOUT - 1))
                    state_d = ST_ERR;
                else
                    arm_cnt_d = arm_cnt_q + ARM_W'(1);
            end
            ST_RUN: begin
                if (done)
                    state_d = ST_ACK;
                else if (wdog_hit || !counting)
                    state_d = ST_ERR;
            end
            ST_ACK:  state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        data_d       = (state_d == ST_PRE || state_d == ST_DLY) ? ser_msb_next : 1'b0;
        ack_d        = (state_d == ST_ACK);
        rsp_valid_d  = (state_d == ST_ACK || state_d == ST_ERR);
        rsp_err_d    = (state_d == ST_ERR);
        rsp_cycles_d = rsp_valid_d ? cyc_d : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            arm_cnt_q    <= '0;
            data_q       <= 1'b0;
            ack_q        <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_cycles_q <= '0;
        end else begin
            state_q      <= state_d;
            arm_cnt_q    <= arm_cnt_d;
            data_q       <= data_d;
            ack_q        <= ack_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            rsp_cycles_q <= rsp_cycles_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign data       = data_q;
    assign ack        = ack_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_cycles = rsp_cycles_q;

endmodule
